vram_arbiter: RTL and testbench

// - Shares the single-port sand VRAM (1 bit/pixel, 640x480) among three requesters: display scan-out
//   (read), sand physics engine (read/write with atomic lock) and user draw/cursor (write).
// - Sits between the VRAM instance and the vga/physics/draw blocks in falling_sand_game_top.
// - Fixed priority with aging for draw; registered VRAM command; 1-cycle RAM read latency.

---
 rtl/sand_pkg.sv | 11 +
 rtl/vram_arbiter.sv | 130 +++++++++++++
 tb/tb_vram_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sand_pkg.sv
// Shared types and geometry for the falling-sand VRAM path.
package sand_pkg;

    typedef enum logic [1:0] {SRC_NONE, SRC_DISP, SRC_PHYS, SRC_DRAW} vram_src_t;
    typedef enum logic {ARB, PHYS_LOCK} vram_arb_state_t;

    localparam int SAND_COLS  = 640;
    localparam int SAND_ROWS  = 480;
    localparam int VRAM_DEPTH = SAND_COLS * SAND_ROWS;

endpackage

// File: rtl/vram_arbiter.sv
// Three-way arbiter for the single-port sand VRAM: display > aged draw > physics > draw,
// with a physics lock for atomic RMW and a tagged 1-cycle read return path.
module vram_arbiter
    import sand_pkg::*;
#(
    parameter int VRAM_ADDR_WIDTH = 19,
    parameter int VRAM_DATA_WIDTH = 1,
    parameter int ACTIVE_COLUMNS  = SAND_COLS,
    parameter int ACTIVE_ROWS     = SAND_ROWS,
    parameter int DRAW_MAX_WAIT   = 8
)(
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       disp_req_i,
    input  logic [VRAM_ADDR_WIDTH-1:0] disp_addr_i,
    output logic                       disp_gnt_o,
    output logic                       disp_rvalid_o,
    output logic [VRAM_DATA_WIDTH-1:0] disp_rdata_o,
    input  logic                       phys_req_i,
    input  logic                       phys_we_i,
    input  logic [VRAM_ADDR_WIDTH-1:0] phys_addr_i,
    input  logic [VRAM_DATA_WIDTH-1:0] phys_wdata_i,
    input  logic                       phys_lock_i,
    output logic                       phys_gnt_o,
    output logic                       phys_rvalid_o,
    output logic [VRAM_DATA_WIDTH-1:0] phys_rdata_o,
    input  logic                       draw_req_i,
    input  logic [VRAM_ADDR_WIDTH-1:0] draw_addr_i,
    input  logic [VRAM_DATA_WIDTH-1:0] draw_wdata_i,
    output logic                       draw_gnt_o,
    output logic                       vram_en_o,
    output logic                       vram_we_o,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_addr_o,
    output logic [VRAM_DATA_WIDTH-1:0] vram_wdata_o,
    input  logic [VRAM_DATA_WIDTH-1:0] vram_rdata_i,
    output logic                       addr_err_o
);

    localparam int AGE_W = $clog2(DRAW_MAX_WAIT + 1);
    localparam logic [VRAM_ADDR_WIDTH:0] DEPTH = (VRAM_ADDR_WIDTH+1)'(ACTIVE_COLUMNS * ACTIVE_ROWS);

    vram_arb_state_t             r_state, w_state_nxt;
    logic [AGE_W-1:0]            r_age;
    logic                        w_age_hi, w_locked, w_in_range, w_issue, w_we;
    vram_src_t                   w_src;
    logic [VRAM_ADDR_WIDTH-1:0]  w_addr;
    logic [VRAM_DATA_WIDTH-1:0]  w_wdata, w_rd;
    logic                        r_en, r_we, r_err;
    logic [VRAM_ADDR_WIDTH-1:0]  r_addr;
    logic [VRAM_DATA_WIDTH-1:0]  r_wdata, r_disp_hold, r_phys_hold;
    vram_src_t                   r_tag1, r_tag2;
    logic                        r_oor1, r_oor2;

    assign w_age_hi = (r_age >= AGE_W'(DRAW_MAX_WAIT));
    // Lock only binds while phys keeps asserting it; the release cycle already arbitrates openly.
    assign w_locked = (r_state == PHYS_LOCK) && phys_lock_i;

    always_comb begin
        w_src       = SRC_NONE;
        w_we        = 1'b0;
        w_addr      = '0;
        w_wdata     = '0;
        w_state_nxt = ARB;
        if (!reset_ni)                             w_src = SRC_NONE;
        else if (disp_req_i)                       w_src = SRC_DISP;
        else if (!w_locked && draw_req_i && w_age_hi) w_src = SRC_DRAW;
        else if (phys_req_i)                       w_src = SRC_PHYS;
        else if (!w_locked && draw_req_i)          w_src = SRC_DRAW;
        case (w_src)
            SRC_DISP: w_addr = disp_addr_i;
            SRC_PHYS: begin w_we = phys_we_i; w_addr = phys_addr_i; w_wdata = phys_wdata_i; end
            SRC_DRAW: begin w_we = 1'b1;      w_addr = draw_addr_i; w_wdata = draw_wdata_i; end
            default:  ;
        endcase
        if (w_locked || (w_src == SRC_PHYS && phys_lock_i))
            w_state_nxt = PHYS_LOCK;
    end

    assign disp_gnt_o = (w_src == SRC_DISP);
    assign phys_gnt_o = (w_src == SRC_PHYS);
    assign draw_gnt_o = (w_src == SRC_DRAW);
    assign w_in_range = ({1'b0, w_addr} < DEPTH);
    assign w_issue    = (w_src != SRC_NONE) && w_in_range;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state     <= ARB;
            r_age       <= '0;
            r_en        <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_tag1      <= SRC_NONE;
            r_tag2      <= SRC_NONE;
            r_oor1      <= 1'b0;
            r_oor2      <= 1'b0;
            r_disp_hold <= '0;
            r_phys_hold <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!draw_req_i || draw_gnt_o) r_age <= '0;
            else if (!w_age_hi)            r_age <= r_age + 1'b1;
            r_en    <= w_issue;
            r_we    <= w_issue && w_we;
            r_addr  <= w_issue ? w_addr : '0;
            r_wdata <= w_issue ? w_wdata : '0;
            r_err   <= (w_src != SRC_NONE) && !w_in_range;
            // Out-of-range reads still return a beat so the requester is never left waiting.
            r_tag1  <= (w_src != SRC_NONE && !w_we) ? w_src : SRC_NONE;
            r_oor1  <= !w_in_range;
            r_tag2  <= r_tag1;
            r_oor2  <= r_oor1;
            if (r_tag2 == SRC_DISP) r_disp_hold <= w_rd;
            if (r_tag2 == SRC_PHYS) r_phys_hold <= w_rd;
        end
    end

    assign w_rd          = r_oor2 ? '0 : vram_rdata_i;
    assign disp_rvalid_o = (r_tag2 == SRC_DISP);
    assign phys_rvalid_o = (r_tag2 == SRC_PHYS);
    assign disp_rdata_o  = disp_rvalid_o ? w_rd : r_disp_hold;
    assign phys_rdata_o  = phys_rvalid_o ? w_rd : r_phys_hold;
    assign vram_en_o     = r_en;
    assign vram_we_o     = r_we;
    assign vram_addr_o   = r_addr;
    assign vram_wdata_o  = r_wdata;
    assign addr_err_o    = r_err;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: per-cycle vector table plus lock/aging/range/reset sequences.
module tb_vram_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        disp_req_i, phys_req_i, phys_we_i, phys_lock_i, draw_req_i;
    logic [18:0] disp_addr_i, phys_addr_i, draw_addr_i;
    logic [0:0]  phys_wdata_i, draw_wdata_i, vram_rdata_i;
    logic        disp_gnt_o, disp_rvalid_o, phys_gnt_o, phys_rvalid_o, draw_gnt_o;
    logic [0:0]  disp_rdata_o, phys_rdata_o, vram_wdata_o;
    logic        vram_en_o, vram_we_o, addr_err_o;
    logic [18:0] vram_addr_o;

    int checks = 0;
    int failures = 0;

    vram_arbiter dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i), .disp_gnt_o(disp_gnt_o),
        .disp_rvalid_o(disp_rvalid_o), .disp_rdata_o(disp_rdata_o),
        .phys_req_i(phys_req_i), .phys_we_i(phys_we_i), .phys_addr_i(phys_addr_i),
        .phys_wdata_i(phys_wdata_i), .phys_lock_i(phys_lock_i), .phys_gnt_o(phys_gnt_o),
        .phys_rvalid_o(phys_rvalid_o), .phys_rdata_o(phys_rdata_o),
        .draw_req_i(draw_req_i), .draw_addr_i(draw_addr_i), .draw_wdata_i(draw_wdata_i),
        .draw_gnt_o(draw_gnt_o),
        .vram_en_o(vram_en_o), .vram_we_o(vram_we_o), .vram_addr_o(vram_addr_o),
        .vram_wdata_o(vram_wdata_o), .vram_rdata_i(vram_rdata_i), .addr_err_o(addr_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic d, p, pwe, w;
        logic eg_d, eg_p, eg_w, e_en, e_we;
        logic [18:0] e_addr;
    } vec_t;

    vec_t tv[9];

    function automatic vec_t mk(logic d, logic p, logic pwe, logic w, logic gd, logic gp,
                                logic gw, logic en, logic we, logic [18:0] a);
        vec_t v;
        v.d = d; v.p = p; v.pwe = pwe; v.w = w;
        v.eg_d = gd; v.eg_p = gp; v.eg_w = gw; v.e_en = en; v.e_we = we; v.e_addr = a;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        disp_req_i = 0; phys_req_i = 0; phys_we_i = 0; phys_lock_i = 0; draw_req_i = 0;
        disp_addr_i = '0; phys_addr_i = '0; draw_addr_i = '0;
        phys_wdata_i = '0; draw_wdata_i = '0;
    endtask

    task automatic chk_gnt(input string nm, input logic d, input logic p, input logic w);
        chk({nm, "_disp_gnt"}, 32'(disp_gnt_o), 32'(d));
        chk({nm, "_phys_gnt"}, 32'(phys_gnt_o), 32'(p));
        chk({nm, "_draw_gnt"}, 32'(draw_gnt_o), 32'(w));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle();
        vram_rdata_i = '0;
        reset_ni = 0;
        tick(); tick();
        #2;
        chk_gnt("reset", 0, 0, 0);
        chk("reset_en", 32'(vram_en_o), 0);
        chk("reset_addr", 32'(vram_addr_o), 0);
        chk("reset_err", 32'(addr_err_o), 0);
        chk("reset_rvalid", 32'({disp_rvalid_o, phys_rvalid_o}), 0);

        tv[0] = mk(1, 1, 0, 1,  1, 0, 0,  0, 0, 19'd0);
        tv[1] = mk(0, 1, 1, 1,  0, 1, 0,  1, 0, 19'd100);
        tv[2] = mk(0, 0, 0, 1,  0, 0, 1,  1, 1, 19'd200);
        tv[3] = mk(0, 0, 0, 0,  0, 0, 0,  1, 1, 19'd300);
        tv[4] = mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 19'd0);
        tv[5] = mk(1, 1, 0, 0,  1, 0, 0,  0, 0, 19'd0);
        tv[6] = mk(0, 1, 0, 0,  0, 1, 0,  1, 0, 19'd100);
        tv[7] = mk(0, 0, 0, 1,  0, 0, 1,  1, 0, 19'd200);
        tv[8] = mk(0, 0, 0, 0,  0, 0, 0,  1, 1, 19'd300);

        @(posedge clk_i); #1;
        reset_ni = 1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            disp_req_i = tv[i].d; phys_req_i = tv[i].p; phys_we_i = tv[i].pwe;
            draw_req_i = tv[i].w;
            disp_addr_i = 19'd100; phys_addr_i = 19'd200; draw_addr_i = 19'd300;
            #2;
            chk_gnt($sformatf("vec%0d", i), tv[i].eg_d, tv[i].eg_p, tv[i].eg_w);
            chk($sformatf("vec%0d_en", i), 32'(vram_en_o), 32'(tv[i].e_en));
            chk($sformatf("vec%0d_we", i), 32'(vram_we_o), 32'(tv[i].e_we));
            chk($sformatf("vec%0d_addr", i), 32'(vram_addr_o), 32'(tv[i].e_addr));
        end

        // physics read with return path
        tick(); idle();
        phys_req_i = 1; phys_addr_i = 19'h12345; #2;
        chk_gnt("prd", 0, 1, 0);
        tick(); idle(); #2;
        chk("prd_en", 32'(vram_en_o), 1);
        chk("prd_we", 32'(vram_we_o), 0);
        chk("prd_addr", 32'(vram_addr_o), 32'h12345);
        tick(); vram_rdata_i = 1; #2;
        chk("prd_rvalid", 32'(phys_rvalid_o), 1);
        chk("prd_rdata", 32'(phys_rdata_o), 1);
        chk("prd_disp_rvalid", 32'(disp_rvalid_o), 0);
        tick(); vram_rdata_i = 0; #2;
        chk("prd_rvalid_off", 32'(phys_rvalid_o), 0);
        chk("prd_rdata_hold", 32'(phys_rdata_o), 1);

        // draw aging against continuous physics
        for (int c = 0; c < 10; c++) begin
            tick(); idle();
            phys_req_i = 1; phys_we_i = 1; draw_req_i = 1; draw_addr_i = 19'd7; #2;
            chk_gnt($sformatf("age%0d", c), 0, c != 8, c == 8);
        end
        tick(); idle();

        // locked physics sequence with a display pulse
        for (int c = 0; c <= 20; c++) begin
            tick(); idle();
            phys_req_i = 1; phys_we_i = 1; phys_lock_i = (c < 20);
            draw_req_i = 1; disp_req_i = (c == 10); #2;
            chk_gnt($sformatf("lock%0d", c), c == 10, c != 10 && c != 20, c == 20);
        end
        tick(); idle(); #2;

        // address range boundary
        tick(); draw_req_i = 1; draw_addr_i = 19'd307199; draw_wdata_i = 1; #2;
        chk_gnt("last_addr", 0, 0, 1);
        tick(); idle(); #2;
        chk("last_en", 32'(vram_en_o), 1);
        chk("last_err", 32'(addr_err_o), 0);
        chk("last_addr_o", 32'(vram_addr_o), 307199);
        tick(); draw_req_i = 1; draw_addr_i = 19'd307200; draw_wdata_i = 1; #2;
        chk_gnt("oor_w", 0, 0, 1);
        tick(); idle(); #2;
        chk("oor_w_en", 32'(vram_en_o), 0);
        chk("oor_w_err", 32'(addr_err_o), 1);
        tick(); #2;
        chk("oor_w_err_pulse", 32'(addr_err_o), 0);
        tick(); phys_req_i = 1; phys_addr_i = 19'd307200; #2;
        chk_gnt("oor_r", 0, 1, 0);
        tick(); idle(); #2;
        chk("oor_r_en", 32'(vram_en_o), 0);
        chk("oor_r_err", 32'(addr_err_o), 1);
        tick(); vram_rdata_i = 1; #2;
        chk("oor_r_rvalid", 32'(phys_rvalid_o), 1);
        chk("oor_r_rdata", 32'(phys_rdata_o), 0);
        tick(); vram_rdata_i = 0;

        // reset kills an in-flight display read
        tick(); disp_req_i = 1; disp_addr_i = 19'd5; #2;
        chk_gnt("rst_rd", 1, 0, 0);
        tick(); idle(); reset_ni = 0; #2;
        chk("rst_rd_en", 32'(vram_en_o), 1);
        tick(); reset_ni = 1; vram_rdata_i = 1; #2;
        chk("rst_disp_rvalid", 32'(disp_rvalid_o), 0);
        chk("rst_disp_rdata", 32'(disp_rdata_o), 0);
        chk("rst_phys_rdata", 32'(phys_rdata_o), 0);
        chk("rst_en", 32'(vram_en_o), 0);
        chk("rst_addr", 32'(vram_addr_o), 0);
        chk_gnt("rst_out", 0, 0, 0);
        tick(); vram_rdata_i = 0;

        // reset releases the physics lock
        tick(); phys_req_i = 1; phys_we_i = 1; phys_lock_i = 1; #2;
        chk_gnt("lk_take", 0, 1, 0);
        tick(); phys_req_i = 0; draw_req_i = 1; draw_addr_i = 19'd9; #2;
        chk_gnt("lk_block", 0, 0, 0);
        tick(); reset_ni = 0; #2;
        chk_gnt("lk_in_reset", 0, 0, 0);
        tick(); reset_ni = 1; #2;
        chk_gnt("lk_released", 0, 0, 1);
        tick(); idle(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
